// File: rtl/uart_xcvr.sv
// uart_xcvr: full-duplex UART transceiver with shared baud tick; parity bit enabled by defining UART_PARITY_EN
module uart_xcvr #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);
  localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {T_IDLE, T_ARM, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_st_t;

  logic [DW-1:0] div_q, div_d;
  logic          tick;

  tx_st_t               ts_q, ts_d;
  logic [OW-1:0]        ttc_q, ttc_d;
  logic [BW-1:0]        tbc_q, tbc_d;
  logic [DATA_BITS-1:0] tsh_q, tsh_d;
  logic                 tbit_end;

  rx_st_t               rs_q, rs_d;
  logic [1:0]           sy_q, sy_d;
  logic                 rxs;
  logic [OW-1:0]        rtc_q, rtc_d;
  logic [BW-1:0]        rbc_q, rbc_d;
  logic [DATA_BITS-1:0] rsh_q, rsh_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rferr_q, rferr_d;
  logic                 rsample;
`ifdef UART_PARITY_EN
  logic                 tpar_q, tpar_d;
  logic                 rpar_q, rpar_d;
  logic                 rperr_q, rperr_d;
`else
  logic                 unused_par;
  assign unused_par = PARITY_ODD;
`endif

  // Free-running divider: one-clk tick every DIV clocks, shared by both directions
  always_comb begin
    tick = div_q == DW'(DIV - 1);
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Divider register
  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else div_q <= div_d;
  end

  // TX state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q  <= T_IDLE;
      ttc_q <= '0;
      tbc_q <= '0;
      tsh_q <= '0;
`ifdef UART_PARITY_EN
      tpar_q <= 1'b0;
`endif
    end else begin
      ts_q  <= ts_d;
      ttc_q <= ttc_d;
      tbc_q <= tbc_d;
      tsh_q <= tsh_d;
`ifdef UART_PARITY_EN
      tpar_q <= tpar_d;
`endif
    end
  end

  // TX next state: ARM waits for the next tick so every bit spans exactly OVERSAMPLE ticks
  always_comb begin
    ts_d = ts_q;
    ttc_d = ttc_q;
    tbc_d = tbc_q;
    tsh_d = tsh_q;
`ifdef UART_PARITY_EN
    tpar_d = tpar_q;
`endif
    tbit_end = tick && ttc_q == OW'(OVERSAMPLE - 1);
    if (ts_q != T_IDLE && ts_q != T_ARM && tick) ttc_d = tbit_end ? '0 : ttc_q + 1'b1;
    case (ts_q)
      T_IDLE: if (tx_valid) begin
        ts_d = T_ARM;
        tsh_d = tx_data;
`ifdef UART_PARITY_EN
        tpar_d = ^tx_data ^ PARITY_ODD;
`endif
      end
      T_ARM: if (tick) begin
        ts_d = T_START;
        ttc_d = '0;
      end
      T_START: if (tbit_end) begin
        ts_d = T_DATA;
        tbc_d = '0;
      end
      T_DATA: if (tbit_end) begin
        tsh_d = tsh_q >> 1;
        tbc_d = tbc_q + 1'b1;
        if (tbc_q == BW'(DATA_BITS - 1)) begin
          tbc_d = '0;
`ifdef UART_PARITY_EN
          ts_d = T_PAR;
`else
          ts_d = T_STOP;
`endif
        end
      end
      T_PAR: if (tbit_end) ts_d = T_STOP;
      T_STOP: if (tbit_end) begin
        tbc_d = tbc_q + 1'b1;
        if (tbc_q == BW'(STOP_BITS - 1)) ts_d = T_IDLE;
      end
      default: ts_d = T_IDLE;
    endcase
  end

  // TX outputs decoded from state
  always_comb begin
    tx_ready = ts_q == T_IDLE;
    tx = ts_q == T_START ? 1'b0 : ts_q == T_DATA ? tsh_q[0] : 1'b1;
`ifdef UART_PARITY_EN
    if (ts_q == T_PAR) tx = tpar_q;
`endif
  end

  // RX synchroniser, state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sy_q     <= 2'b11;
      rs_q     <= R_IDLE;
      rtc_q    <= '0;
      rbc_q    <= '0;
      rsh_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      rpar_q  <= 1'b0;
      rperr_q <= 1'b0;
`endif
    end else begin
      sy_q     <= sy_d;
      rs_q     <= rs_d;
      rtc_q    <= rtc_d;
      rbc_q    <= rbc_d;
      rsh_q    <= rsh_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rferr_q  <= rferr_d;
`ifdef UART_PARITY_EN
      rpar_q  <= rpar_d;
      rperr_q <= rperr_d;
`endif
    end
  end

  // RX next state: half-bit wait in START centres every later sample mid-bit
  always_comb begin
    sy_d = {sy_q[0], rx};
    rxs = sy_q[1];
    rs_d = rs_q;
    rtc_d = rtc_q;
    rbc_d = rbc_q;
    rsh_d = rsh_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    rferr_d = rferr_q;
`ifdef UART_PARITY_EN
    rpar_d = rpar_q;
    rperr_d = rperr_q;
`endif
    rsample = tick && rtc_q == (rs_q == R_START ? OW'(OVERSAMPLE / 2 - 1) : OW'(OVERSAMPLE - 1));
    if (tick) rtc_d = rsample ? '0 : rtc_q + 1'b1;
    case (rs_q)
      R_IDLE: begin
        rtc_d = '0;
        if (tick && !rxs) rs_d = R_START;
      end
      R_START: if (rsample) begin
        rs_d = rxs ? R_IDLE : R_DATA;
        rbc_d = '0;
      end
      R_DATA: if (rsample) begin
        rsh_d = {rxs, rsh_q[DATA_BITS-1:1]};
        rbc_d = rbc_q + 1'b1;
`ifdef UART_PARITY_EN
        if (rbc_q == BW'(DATA_BITS - 1)) rs_d = R_PAR;
`else
        if (rbc_q == BW'(DATA_BITS - 1)) rs_d = R_STOP;
`endif
      end
      R_PAR: if (rsample) begin
`ifdef UART_PARITY_EN
        rpar_d = rxs;
`endif
        rs_d = R_STOP;
      end
      R_STOP: if (rsample) begin
        rdata_d = rsh_q;
        rvalid_d = 1'b1;
        rferr_d = !rxs;
`ifdef UART_PARITY_EN
        rperr_d = (^rsh_q ^ PARITY_ODD) != rpar_q;
`endif
        rs_d = rxs ? R_IDLE : R_WAIT;
      end
      R_WAIT: if (rxs) rs_d = R_IDLE;
      default: rs_d = R_IDLE;
    endcase
  end

  // RX outputs driven from registers
  always_comb begin
    rx_busy = rs_q != R_IDLE;
    rx_data = rdata_q;
    rx_valid = rvalid_q;
    rx_frame_err = rferr_q;
`ifdef UART_PARITY_EN
    rx_parity_err = rperr_q;
`else
    rx_parity_err = 1'b0;
`endif
  end
endmodule
